// File: rtl/mult_share_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
//   Shared constants and types for the multiplier-sharing controller.
//   OPW / PRODW   : operand and product widths of the shared 8x8 multiplier
//   rsp_entry_t   : one response FIFO entry {requester id, product}
//   clog2()       : elaboration-time ceil(log2) used to size ids and pointers
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

    localparam int OPW     = 8;
    localparam int PRODW   = 16;
    // Widest requester id (N_REQ up to 8); narrower ids are zero-extended.
    localparam int IDW_MAX = 3;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [PRODW-1:0]   prod;
    } rsp_entry_t;

    localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter: grants the first asserted request found when scanning
//   upward from the pointer with wrap-around. A grant is only produced when
//   en is high; every grant is a completed handshake, so the pointer advances
//   to grant+1 (mod N) whenever grant_valid is set and holds otherwise.
// Ports
//   clk, rst_n   : clock, synchronous active-low reset (pointer -> 0)
//   req          : per-requester request vector
//   en           : permission to grant this cycle (credit available)
//   grant        : one-hot grant (or zero)
//   grant_idx    : index of the granted requester
//   grant_valid  : a grant was produced this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Scan offsets from highest to lowest so the smallest offset from the
    // pointer is the one left standing.
    always_comb begin
        int cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = int'(ptr_q) + k;
                if (cand >= N) begin
                    cand = cand - N;
                end
                if (req[cand]) begin
                    grant_idx   = PW'(cand);
                    grant_valid = 1'b1;
                end
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
//   Shares one external 8x8 multiplier between N_REQ requesters. One request
//   is issued per cycle under round-robin arbitration; operands are registered
//   onto mul_a/mul_b, a {valid,id} tag travels alongside through a MUL_LAT deep
//   shift register, and when the tag leaves the pipe mul_prod is written into
//   a response FIFO. Credits (in-flight + queued) never exceed FIFO_DEPTH, so
//   the FIFO cannot overflow and needs no back-pressure toward the multiplier.
// Ports
//   clk, rst_n          : clock, synchronous active-low reset (drops all ops)
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a/req_b         : packed operands, requester i at [8i+7:8i]
//   mul_a/mul_b         : registered operands to the shared multiplier
//   mul_prod            : multiplier result, sampled MUL_LAT cycles after issue
//   rsp_valid/rsp_ready : response handshake at the FIFO head
//   rsp_prod/rsp_id     : product and requester index of the FIFO head
//   busy                : any op in the tag pipe or in the FIFO
// -----------------------------------------------------------------------------
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  MUL_LAT    = 1,
    parameter int  FIFO_DEPTH = 4,
    localparam int IDW        = clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [OPW*N_REQ-1:0] req_a,
    input  logic [OPW*N_REQ-1:0] req_b,
    output logic [OPW-1:0]       mul_a,
    output logic [OPW-1:0]       mul_b,
    input  logic [PRODW-1:0]     mul_prod,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRODW-1:0]     rsp_prod,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // ---------------- credit and arbitration ----------------
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW:0]      credit_used;
    logic             issue_ok;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             issue;

    // Credit uses registered counts only, so a pop frees a slot next cycle.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_ok    = credit_used < (CW + 1)'(FIFO_DEPTH);

    rr_arbiter #(
        .N  (N_REQ),
        .PW (IDW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .en          (issue_ok & rst_n),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (issue)
    );

    assign req_ready = grant;

    // ---------------- operand registers ----------------
    logic [OPW-1:0] mul_a_q, mul_a_d;
    logic [OPW-1:0] mul_b_q, mul_b_d;

    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (issue) begin
            mul_a_d = req_a[grant_idx*OPW +: OPW];
            mul_b_d = req_b[grant_idx*OPW +: OPW];
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    // ---------------- tag pipe ----------------
    logic [MUL_LAT-1:0] pv_q;
    logic [IDW-1:0]     pid_q [MUL_LAT];
    logic               exit_valid;
    logic [IDW-1:0]     exit_id;

    assign exit_valid = pv_q[MUL_LAT-1];
    assign exit_id    = pid_q[MUL_LAT-1];

    // ---------------- response FIFO ----------------
    rsp_entry_t    mem_q [FIFO_DEPTH];
    rsp_entry_t    push_entry;
    rsp_entry_t    head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push;
    logic          pop;
    logic          unused_id_bits;

    assign push            = exit_valid;
    assign rsp_valid       = (count_q != '0);
    assign pop             = rsp_valid & rsp_ready;
    assign push_entry.id   = IDW_MAX'(exit_id);
    assign push_entry.prod = mul_prod;
    assign head            = mem_q[rd_ptr_q];
    assign rsp_prod        = head.prod;
    assign rsp_id          = head.id[IDW-1:0];
    assign unused_id_bits  = ^head.id;

    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        case ({issue, exit_valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        // Depth is a power of two, so the pointers wrap on their own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // FIFO storage carries no reset; reset empties it through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                pv_q[s]  <= 1'b0;
                pid_q[s] <= '0;
            end
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pv_q[0]    <= issue;
            pid_q[0]   <= grant_idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                pv_q[s]  <= pv_q[s-1];
                pid_q[s] <= pid_q[s-1];
            end
            // The credit limit must keep a push away from a full FIFO.
            assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
        end
    end

    assign busy = (|pv_q) | (count_q != '0);

endmodule
